param_reg_bank: RTL and testbench

PARAM_REG_BANK -- requirements
Module: param_reg_bank

---
 rtl/param_reg_bank.sv | 103 ++++++++++
 tb/tb_param_reg_bank.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/param_reg_bank.sv
// Two-read/one-write register bank with per-entry pending-write (busy) bits; reads are registered, 1-cycle latency.
// Optional macro REGBANK_BYPASS_EN forwards same-edge write data to a matching read.
module param_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rad1,
  input  logic [ADDR_W-1:0] rad2,
  input  logic              r1,
  input  logic              r2,
  input  logic [ADDR_W-1:0] wad,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_ad,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid1,
  output logic              rvalid2,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              wr_ok;
  logic              rsv_ok;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] nd [2];
  logic              nb [2];

  // Entry 0 is hard-wired when ZERO_REG is set, so writes and reserves to it are dropped.
  assign wr_ok  = wen    && !((ZERO_REG != 0) && (wad == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_ad == '0));
  assign ra[0]  = rad1;
  assign ra[1]  = rad2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[wad]  <= wdata;
        busy[wad] <= 1'b0;
      end
      // Placed after the clear so a same-edge reservation of the written entry wins.
      if (rsv_ok) busy[rsv_ad] <= 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      nd[p] = mem[ra[p]];
      nb[p] = busy[ra[p]];
`ifdef REGBANK_BYPASS_EN
      if (wr_ok && (wad == ra[p])) begin
        nd[p] = wdata;
        nb[p] = rsv_ok && (rsv_ad == wad);
      end
`endif
      if ((ZERO_REG != 0) && (ra[p] == '0)) begin
        nd[p] = '0;
        nb[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1  <= '0;
      busy1   <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid1 <= r1;
      if (r1) begin
        rdata1 <= nd[0];
        busy1  <= nb[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata2  <= '0;
      busy2   <= 1'b0;
      rvalid2 <= 1'b0;
    end else begin
      rvalid2 <= r2;
      if (r2) begin
        rdata2 <= nd[1];
        busy2  <= nb[1];
      end
    end
  end

endmodule

// File: tb/tb_param_reg_bank.sv
// Directed, table-driven bench for param_reg_bank (DATA_W=32, ADDR_W=4, ZERO_REG=1).
module tb_param_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rad1, rad2, wad, rsv_ad;
  logic        r1, r2, wen, rsv_en;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2, busy1, busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_reg_bank #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rad1(rad1), .rad2(rad2), .r1(r1), .r2(r2),
    .wad(wad), .wdata(wdata), .wen(wen),
    .rsv_en(rsv_en), .rsv_ad(rsv_ad),
    .rdata1(rdata1), .rdata2(rdata2),
    .rvalid1(rvalid1), .rvalid2(rvalid2),
    .busy1(busy1), .busy2(busy2)
  );

`ifdef REGBANK_BYPASS_EN
  localparam logic [31:0] R7  = 32'h2;
  localparam logic [31:0] R8D = 32'h77;
  localparam logic        R8B = 1'b1;
`else
  localparam logic [31:0] R7  = 32'h1;
  localparam logic [31:0] R8D = 32'h0;
  localparam logic        R8B = 1'b0;
`endif

  typedef struct {
    logic        wen;
    logic [3:0]  wad;
    logic [31:0] wdata;
    logic        rsv_en;
    logic [3:0]  rsv_ad;
    logic        r1;
    logic [3:0]  rad1;
    logic        r2;
    logic [3:0]  rad2;
    logic [31:0] rd1;
    logic        b1;
    logic        v1;
    logic [31:0] rd2;
    logic        b2;
    logic        v2;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_rd1, input logic e_b1, input logic e_v1,
                           input logic [31:0] e_rd2, input logic e_b2, input logic e_v2);
    check({tag, ".rdata1"},  rdata1,  e_rd1);
    check({tag, ".busy1"},   {31'b0, busy1},   {31'b0, e_b1});
    check({tag, ".rvalid1"}, {31'b0, rvalid1}, {31'b0, e_v1});
    check({tag, ".rdata2"},  rdata2,  e_rd2);
    check({tag, ".busy2"},   {31'b0, busy2},   {31'b0, e_b2});
    check({tag, ".rvalid2"}, {31'b0, rvalid2}, {31'b0, e_v2});
  endtask

  task automatic drive_idle();
    wen = 1'b0; wad = '0; wdata = '0; rsv_en = 1'b0; rsv_ad = '0;
    r1 = 1'b0; rad1 = '0; r2 = 1'b0; rad2 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 check_all("reset", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    //        wen  wad    wdata           rsv  rsad   r1  rad1   r2  rad2   rd1            b1  v1  rd2            b2  v2
    tv.push_back('{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b1, 4'd0, 32'h12345678, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b1, 4'd3, 32'h55,       1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 32'h55,       1'b0, 1'b1, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b1, 4'd3, 32'h66,       1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 32'h55,       1'b0, 1'b0, 32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd3, 32'h66,       1'b1, 1'b1, 32'h66,       1'b1, 1'b1});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 32'h66,       1'b1, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd6, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1});
    tv.push_back('{1'b1, 4'd7, 32'h1,        1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0});
    tv.push_back('{1'b1, 4'd7, 32'h2,        1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, R7,           1'b0, 1'b1, 32'h0,        1'b1, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 32'h2,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0});
    tv.push_back('{1'b1, 4'd4, 32'hCAFEF00D, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h2,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 4'd4, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0});
    tv.push_back('{1'b1, 4'd8, 32'h77,       1'b1, 4'd8, 1'b1, 4'd8, 1'b0, 4'd0, R8D,          R8B,  1'b1, 32'hCAFEF00D, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd8, R8D,          R8B,  1'b0, 32'h77,       1'b1, 1'b1});
    tv.push_back('{1'b1, 4'd0, 32'hFFFF,     1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, R8D,          R8B,  1'b0, 32'h0,        1'b0, 1'b1});

    foreach (tv[k]) begin
      @(negedge clk);
      wen = tv[k].wen; wad = tv[k].wad; wdata = tv[k].wdata;
      rsv_en = tv[k].rsv_en; rsv_ad = tv[k].rsv_ad;
      r1 = tv[k].r1; rad1 = tv[k].rad1; r2 = tv[k].r2; rad2 = tv[k].rad2;
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", k), tv[k].rd1, tv[k].b1, tv[k].v1, tv[k].rd2, tv[k].b2, tv[k].v2);
    end

    // Asynchronous reset mid-cycle with a read in flight, then writes ignored while held.
    @(negedge clk) drive_idle(); wen = 1'b1; wad = 4'd9; wdata = 32'hA5A5A5A5;
    @(negedge clk) drive_idle(); rsv_en = 1'b1; rsv_ad = 4'd9;
    @(negedge clk) drive_idle(); r1 = 1'b1; rad1 = 4'd9; r2 = 1'b1; rad2 = 4'd4;
    @(posedge clk);
    #1 check_all("pre_rst", 32'hA5A5A5A5, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk) wen = 1'b1; wad = 4'd10; wdata = 32'hBB; rsv_en = 1'b1; rsv_ad = 4'd11;
    @(posedge clk);
    #1 check_all("in_rst", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1; drive_idle(); r1 = 1'b1; rad1 = 4'd9; r2 = 1'b1; rad2 = 4'd10;
    @(posedge clk);
    #1 check_all("post_rst", 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    @(negedge clk) drive_idle(); r1 = 1'b1; rad1 = 4'd11;
    @(posedge clk);
    #1 check_all("post_rst_rsv", 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
